// File: rtl/physical_reg_file.sv
// Physical register file with rename free-list allocation, dual CDB writeback and four read ports.
// Optional macro PRF_CDB_BYPASS_EN forwards same-cycle CDB results to the read ports.
module physical_reg_file #(
    parameter  int PRF_SIZE = 64,
    localparam int IW       = $clog2(PRF_SIZE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cdb1_valid,
    input  logic                cdb2_valid,
    input  logic [IW-1:0]       cdb1_tag,
    input  logic [IW-1:0]       cdb2_tag,
    input  logic [63:0]         cdb1_out,
    input  logic [63:0]         cdb2_out,
    input  logic [IW-1:0]       inst1_opa_prf_idx,
    input  logic [IW-1:0]       inst1_opb_prf_idx,
    input  logic [IW-1:0]       inst2_opa_prf_idx,
    input  logic [IW-1:0]       inst2_opb_prf_idx,
    input  logic                rat1_allocate_new_prf,
    input  logic                rat2_allocate_new_prf,
    input  logic [PRF_SIZE-1:0] rrat1_prf_free_list,
    input  logic [PRF_SIZE-1:0] rrat2_prf_free_list,
    input  logic [PRF_SIZE-1:0] rat1_prf_free_list,
    input  logic [PRF_SIZE-1:0] rat2_prf_free_list,
    input  logic                rrat1_branch_mistaken_free_valid,
    input  logic                rrat2_branch_mistaken_free_valid,
    input  logic                rrat1_prf_free_valid,
    input  logic                rrat2_prf_free_valid,
    input  logic [IW-1:0]       rrat1_prf_free_idx,
    input  logic [IW-1:0]       rrat2_prf_free_idx,
    output logic                rat1_prf_rename_valid_out,
    output logic                rat2_prf_rename_valid_out,
    output logic [IW-1:0]       rat1_prf_rename_idx_out,
    output logic [IW-1:0]       rat2_prf_rename_idx_out,
    output logic                inst1_opa_valid,
    output logic                inst1_opb_valid,
    output logic                inst2_opa_valid,
    output logic                inst2_opb_valid,
    output logic [63:0]         inst1_opa_prf_value,
    output logic [63:0]         inst1_opb_prf_value,
    output logic [63:0]         inst2_opa_prf_value,
    output logic [63:0]         inst2_opb_prf_value
);

    logic [PRF_SIZE-1:0] allocated_q;
    logic [PRF_SIZE-1:0] ready_q;
    logic [63:0]         value_q [PRF_SIZE];

    logic [PRF_SIZE-1:0] alloc_next;
    logic [PRF_SIZE-1:0] ready_next;
    logic                recover;
    logic                g1_found;
    logic                g2_found;
    logic [IW-1:0]       g1_idx;
    logic [IW-1:0]       g2_idx;
    logic                grant1;
    logic                grant2;

    // The rename-side free lists are carried on the interface but never consulted.
    logic unused_rat_free_lists;
    assign unused_rat_free_lists = ^{rat1_prf_free_list, rat2_prf_free_list};

    assign recover = rrat1_branch_mistaken_free_valid | rrat2_branch_mistaken_free_valid;

    always_comb begin
        g1_found = 1'b0;
        g1_idx   = '0;
        for (int i = PRF_SIZE - 1; i >= 0; i--) begin
            if (!allocated_q[i]) begin
                g1_found = 1'b1;
                g1_idx   = IW'(i);
            end
        end
        grant1 = rat1_allocate_new_prf && g1_found && !recover;

        // rat2 searches from the top and must not collide with rat1's grant.
        g2_found = 1'b0;
        g2_idx   = '0;
        for (int i = 0; i < PRF_SIZE; i++) begin
            if (!allocated_q[i] && !(grant1 && (g1_idx == IW'(i)))) begin
                g2_found = 1'b1;
                g2_idx   = IW'(i);
            end
        end
        grant2 = rat2_allocate_new_prf && g2_found && !recover;

        rat1_prf_rename_valid_out = grant1;
        rat1_prf_rename_idx_out   = grant1 ? g1_idx : '0;
        rat2_prf_rename_valid_out = grant2;
        rat2_prf_rename_idx_out   = grant2 ? g2_idx : '0;
    end

    always_comb begin
        alloc_next = allocated_q;
        if (recover) begin
            alloc_next = rrat1_prf_free_list | rrat2_prf_free_list;
        end else begin
            if (rrat1_prf_free_valid) alloc_next[rrat1_prf_free_idx] = 1'b0;
            if (rrat2_prf_free_valid) alloc_next[rrat2_prf_free_idx] = 1'b0;
            if (grant1)               alloc_next[g1_idx]             = 1'b1;
            if (grant2)               alloc_next[g2_idx]             = 1'b1;
        end

        ready_next = ready_q;
        if (grant1)     ready_next[g1_idx]   = 1'b0;
        if (grant2)     ready_next[g2_idx]   = 1'b0;
        if (cdb2_valid) ready_next[cdb2_tag] = 1'b1;
        if (cdb1_valid) ready_next[cdb1_tag] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            allocated_q <= '0;
            ready_q     <= '1;
            for (int i = 0; i < PRF_SIZE; i++) value_q[i] <= '0;
        end else begin
            allocated_q <= alloc_next;
            ready_q     <= ready_next;
            // cdb1 is written last so it wins a tag collision.
            if (cdb2_valid) value_q[cdb2_tag] <= cdb2_out;
            if (cdb1_valid) value_q[cdb1_tag] <= cdb1_out;
        end
    end

    function automatic logic [64:0] read_port(input logic [IW-1:0] idx);
`ifdef PRF_CDB_BYPASS_EN
        if (cdb1_valid && (cdb1_tag == idx)) return {1'b1, cdb1_out};
        if (cdb2_valid && (cdb2_tag == idx)) return {1'b1, cdb2_out};
`endif
        return {ready_q[idx], value_q[idx]};
    endfunction

    always_comb begin
        {inst1_opa_valid, inst1_opa_prf_value} = read_port(inst1_opa_prf_idx);
        {inst1_opb_valid, inst1_opb_prf_value} = read_port(inst1_opb_prf_idx);
        {inst2_opa_valid, inst2_opa_prf_value} = read_port(inst2_opa_prf_idx);
        {inst2_opb_valid, inst2_opb_prf_value} = read_port(inst2_opb_prf_idx);
    end

endmodule

// File: tb/tb_physical_reg_file.sv
// Directed bench for physical_reg_file against a free-list/array reference model.
module tb_physical_reg_file;
    localparam int N  = 64;
    localparam int IW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          cdb1_valid, cdb2_valid;
    logic [IW-1:0] cdb1_tag, cdb2_tag;
    logic [63:0]   cdb1_out, cdb2_out;
    logic [IW-1:0] inst1_opa_prf_idx, inst1_opb_prf_idx, inst2_opa_prf_idx, inst2_opb_prf_idx;
    logic          rat1_allocate_new_prf, rat2_allocate_new_prf;
    logic [N-1:0]  rrat1_prf_free_list, rrat2_prf_free_list, rat1_prf_free_list, rat2_prf_free_list;
    logic          rrat1_branch_mistaken_free_valid, rrat2_branch_mistaken_free_valid;
    logic          rrat1_prf_free_valid, rrat2_prf_free_valid;
    logic [IW-1:0] rrat1_prf_free_idx, rrat2_prf_free_idx;
    logic          rat1_prf_rename_valid_out, rat2_prf_rename_valid_out;
    logic [IW-1:0] rat1_prf_rename_idx_out, rat2_prf_rename_idx_out;
    logic          inst1_opa_valid, inst1_opb_valid, inst2_opa_valid, inst2_opb_valid;
    logic [63:0]   inst1_opa_prf_value, inst1_opb_prf_value, inst2_opa_prf_value, inst2_opb_prf_value;

    physical_reg_file #(.PRF_SIZE(N)) dut (
        .clock(clock), .reset(reset),
        .cdb1_valid(cdb1_valid), .cdb2_valid(cdb2_valid),
        .cdb1_tag(cdb1_tag), .cdb2_tag(cdb2_tag),
        .cdb1_out(cdb1_out), .cdb2_out(cdb2_out),
        .inst1_opa_prf_idx(inst1_opa_prf_idx), .inst1_opb_prf_idx(inst1_opb_prf_idx),
        .inst2_opa_prf_idx(inst2_opa_prf_idx), .inst2_opb_prf_idx(inst2_opb_prf_idx),
        .rat1_allocate_new_prf(rat1_allocate_new_prf), .rat2_allocate_new_prf(rat2_allocate_new_prf),
        .rrat1_prf_free_list(rrat1_prf_free_list), .rrat2_prf_free_list(rrat2_prf_free_list),
        .rat1_prf_free_list(rat1_prf_free_list), .rat2_prf_free_list(rat2_prf_free_list),
        .rrat1_branch_mistaken_free_valid(rrat1_branch_mistaken_free_valid),
        .rrat2_branch_mistaken_free_valid(rrat2_branch_mistaken_free_valid),
        .rrat1_prf_free_valid(rrat1_prf_free_valid), .rrat2_prf_free_valid(rrat2_prf_free_valid),
        .rrat1_prf_free_idx(rrat1_prf_free_idx), .rrat2_prf_free_idx(rrat2_prf_free_idx),
        .rat1_prf_rename_valid_out(rat1_prf_rename_valid_out),
        .rat2_prf_rename_valid_out(rat2_prf_rename_valid_out),
        .rat1_prf_rename_idx_out(rat1_prf_rename_idx_out),
        .rat2_prf_rename_idx_out(rat2_prf_rename_idx_out),
        .inst1_opa_valid(inst1_opa_valid), .inst1_opb_valid(inst1_opb_valid),
        .inst2_opa_valid(inst2_opa_valid), .inst2_opb_valid(inst2_opb_valid),
        .inst1_opa_prf_value(inst1_opa_prf_value), .inst1_opb_prf_value(inst1_opb_prf_value),
        .inst2_opa_prf_value(inst2_opa_prf_value), .inst2_opb_prf_value(inst2_opb_prf_value)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    bit          m_alloc [N];
    bit          m_ready [N];
    logic [63:0] m_value [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_grants(output bit v1, output logic [IW-1:0] i1,
                                         output bit v2, output logic [IW-1:0] i2);
        int free_q[$];
        v1 = 0; i1 = '0; v2 = 0; i2 = '0;
        if (rrat1_branch_mistaken_free_valid || rrat2_branch_mistaken_free_valid) return;
        for (int i = 0; i < N; i++) if (!m_alloc[i]) free_q.push_back(i);
        if (rat1_allocate_new_prf && free_q.size() > 0) begin v1 = 1; i1 = IW'(free_q.pop_front()); end
        if (rat2_allocate_new_prf && free_q.size() > 0) begin v2 = 1; i2 = IW'(free_q.pop_back()); end
    endfunction

    function automatic void model_read(input logic [IW-1:0] idx, output bit v, output logic [63:0] val);
        v = m_ready[idx]; val = m_value[idx];
`ifdef PRF_CDB_BYPASS_EN
        if (cdb2_valid && cdb2_tag == idx) begin v = 1; val = cdb2_out; end
        if (cdb1_valid && cdb1_tag == idx) begin v = 1; val = cdb1_out; end
`endif
    endfunction

    always @(posedge clock) begin
        bit v1, v2;
        logic [IW-1:0] i1, i2;
        if (reset) begin
            for (int i = 0; i < N; i++) begin m_alloc[i] = 0; m_ready[i] = 1; m_value[i] = '0; end
        end else begin
            model_grants(v1, i1, v2, i2);
            if (rrat1_branch_mistaken_free_valid || rrat2_branch_mistaken_free_valid) begin
                for (int i = 0; i < N; i++) m_alloc[i] = rrat1_prf_free_list[i] | rrat2_prf_free_list[i];
            end else begin
                if (rrat1_prf_free_valid) m_alloc[rrat1_prf_free_idx] = 0;
                if (rrat2_prf_free_valid) m_alloc[rrat2_prf_free_idx] = 0;
            end
            if (v1) begin m_alloc[i1] = 1; m_ready[i1] = 0; end
            if (v2) begin m_alloc[i2] = 1; m_ready[i2] = 0; end
            if (cdb2_valid) begin m_ready[cdb2_tag] = 1; m_value[cdb2_tag] = cdb2_out; end
            if (cdb1_valid) begin m_ready[cdb1_tag] = 1; m_value[cdb1_tag] = cdb1_out; end
        end
    end

    task automatic check_read(input string name, input logic [IW-1:0] idx,
                              input logic v, input logic [63:0] val);
        bit ev;
        logic [63:0] eval;
        model_read(idx, ev, eval);
        check({name, "_valid"}, {63'b0, v}, {63'b0, ev});
        check({name, "_value"}, val, eval);
    endtask

    always @(negedge clock) begin
        bit v1, v2;
        logic [IW-1:0] i1, i2;
        if (chk_en) begin
            model_grants(v1, i1, v2, i2);
            check("rat1_valid", {63'b0, rat1_prf_rename_valid_out}, {63'b0, v1});
            check("rat1_idx", {58'b0, rat1_prf_rename_idx_out}, {58'b0, i1});
            check("rat2_valid", {63'b0, rat2_prf_rename_valid_out}, {63'b0, v2});
            check("rat2_idx", {58'b0, rat2_prf_rename_idx_out}, {58'b0, i2});
            check_read("i1a", inst1_opa_prf_idx, inst1_opa_valid, inst1_opa_prf_value);
            check_read("i1b", inst1_opb_prf_idx, inst1_opb_valid, inst1_opb_prf_value);
            check_read("i2a", inst2_opa_prf_idx, inst2_opa_valid, inst2_opa_prf_value);
            check_read("i2b", inst2_opb_prf_idx, inst2_opb_valid, inst2_opb_prf_value);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        cdb1_valid = 0; cdb2_valid = 0; cdb1_tag = '0; cdb2_tag = '0; cdb1_out = '0; cdb2_out = '0;
        inst1_opa_prf_idx = '0; inst1_opb_prf_idx = '0; inst2_opa_prf_idx = '0; inst2_opb_prf_idx = '0;
        rat1_allocate_new_prf = 0; rat2_allocate_new_prf = 0;
        rrat1_prf_free_list = '0; rrat2_prf_free_list = '0;
        rat1_prf_free_list = '1; rat2_prf_free_list = '1;
        rrat1_branch_mistaken_free_valid = 0; rrat2_branch_mistaken_free_valid = 0;
        rrat1_prf_free_valid = 0; rrat2_prf_free_valid = 0;
        rrat1_prf_free_idx = '0; rrat2_prf_free_idx = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick();
        chk_en = 1;
        @(negedge clock);
        check("reset_rat1_valid", {63'b0, rat1_prf_rename_valid_out}, 64'd0);
        check("reset_read_valid", {63'b0, inst1_opa_valid}, 64'd1);
        check("reset_read_value", inst1_opa_prf_value, 64'd0);
        tick();
        reset = 0;

        // rat1 alone on alternating cycles
        for (int k = 0; k < 3; k++) begin
            rat1_allocate_new_prf = 1;
            @(negedge clock);
            check("alt_grant_valid", {63'b0, rat1_prf_rename_valid_out}, 64'd1);
            check("alt_grant_idx", {58'b0, rat1_prf_rename_idx_out}, 64'(k));
            tick();
            rat1_allocate_new_prf = 0;
            @(negedge clock);
            check("idle_valid", {63'b0, rat1_prf_rename_valid_out}, 64'd0);
            check("idle_idx", {58'b0, rat1_prf_rename_idx_out}, 64'd0);
            tick();
        end

        // both request after reset
        do_reset();
        rat1_allocate_new_prf = 1; rat2_allocate_new_prf = 1;
        @(negedge clock);
        check("dual_rat1_idx", {58'b0, rat1_prf_rename_idx_out}, 64'd0);
        check("dual_rat2_idx", {58'b0, rat2_prf_rename_idx_out}, 64'd63);
        check("dual_rat2_valid", {63'b0, rat2_prf_rename_valid_out}, 64'd1);
        tick();
        rat1_allocate_new_prf = 0; rat2_allocate_new_prf = 0;

        // CDB write then read of entry 0
        inst1_opa_prf_idx = '0;
        @(negedge clock);
        check("prewrite_valid", {63'b0, inst1_opa_valid}, 64'd0);
        cdb1_valid = 1; cdb1_tag = '0; cdb1_out = 64'hDEAD_BEEF;
        tick();
        cdb1_valid = 0;
        @(negedge clock);
        check("postwrite_valid", {63'b0, inst1_opa_valid}, 64'd1);
        check("postwrite_value", inst1_opa_prf_value, 64'hDEAD_BEEF);
        tick();

        // exhaust the free list, then retire/free
        do_reset();
        rat1_allocate_new_prf = 1; rat2_allocate_new_prf = 1;
        repeat (32) tick();
        @(negedge clock);
        check("full_rat1_valid", {63'b0, rat1_prf_rename_valid_out}, 64'd0);
        check("full_rat2_valid", {63'b0, rat2_prf_rename_valid_out}, 64'd0);
        rrat1_prf_free_valid = 1; rrat1_prf_free_idx = 6'd5;
        tick();
        rrat1_prf_free_valid = 0;
        @(negedge clock);
        check("refree_rat1_idx", {58'b0, rat1_prf_rename_idx_out}, 64'd5);
        check("refree_rat1_valid", {63'b0, rat1_prf_rename_valid_out}, 64'd1);
        check("refree_rat2_valid", {63'b0, rat2_prf_rename_valid_out}, 64'd0);
        tick();
        rrat2_prf_free_valid = 1; rrat2_prf_free_idx = 6'd9;
        @(negedge clock);
        check("free_same_cycle_grant", {63'b0, rat1_prf_rename_valid_out}, 64'd0);
        tick();
        rrat2_prf_free_valid = 0;
        @(negedge clock);
        check("free_next_cycle_idx", {58'b0, rat1_prf_rename_idx_out}, 64'd9);
        tick();
        rrat1_prf_free_valid = 1; rrat1_prf_free_idx = 6'd3;
        rrat2_prf_free_valid = 1; rrat2_prf_free_idx = 6'd40;
        tick();
        rrat1_prf_free_valid = 0; rrat2_prf_free_valid = 0;
        @(negedge clock);
        check("dualfree_rat1_idx", {58'b0, rat1_prf_rename_idx_out}, 64'd3);
        check("dualfree_rat2_idx", {58'b0, rat2_prf_rename_idx_out}, 64'd40);
        tick();
        rat1_allocate_new_prf = 0; rat2_allocate_new_prf = 0;

        // mispredict recovery
        do_reset();
        rat1_allocate_new_prf = 1;
        repeat (10) tick();
        rrat1_branch_mistaken_free_valid = 1; rrat1_prf_free_list = 64'h3;
        rrat1_prf_free_valid = 1; rrat1_prf_free_idx = 6'd1;
        rat2_allocate_new_prf = 1;
        @(negedge clock);
        check("recover_rat1_valid", {63'b0, rat1_prf_rename_valid_out}, 64'd0);
        check("recover_rat2_valid", {63'b0, rat2_prf_rename_valid_out}, 64'd0);
        tick();
        rrat1_branch_mistaken_free_valid = 0; rrat1_prf_free_list = '0;
        rrat1_prf_free_valid = 0; rat2_allocate_new_prf = 0;
        @(negedge clock);
        check("after_recover_idx", {58'b0, rat1_prf_rename_idx_out}, 64'd2);
        check("after_recover_valid", {63'b0, rat1_prf_rename_valid_out}, 64'd1);
        tick();
        rat1_allocate_new_prf = 0;

        // CDB collision: cdb1 wins; cdb2 alone
        cdb1_valid = 1; cdb1_tag = 6'd3; cdb1_out = 64'hAAAA_0001;
        cdb2_valid = 1; cdb2_tag = 6'd3; cdb2_out = 64'hBBBB_0002;
        inst2_opa_prf_idx = 6'd3; inst2_opb_prf_idx = 6'd4; inst1_opb_prf_idx = 6'd2;
        tick();
        cdb1_valid = 0;
        cdb2_tag = 6'd4; cdb2_out = 64'hCCCC_0003;
        @(negedge clock);
        check("collision_value", inst2_opa_prf_value, 64'hAAAA_0001);
        check("alloc_not_ready", {63'b0, inst1_opb_valid}, 64'd0);
        tick();
        cdb2_valid = 0;
        @(negedge clock);
        check("cdb2_value", inst2_opb_prf_value, 64'hCCCC_0003);
        check("cdb2_valid", {63'b0, inst2_opb_valid}, 64'd1);
        tick();

`ifdef PRF_CDB_BYPASS_EN
        inst1_opb_prf_idx = 6'd7;
        cdb2_valid = 1; cdb2_tag = 6'd7; cdb2_out = 64'h1234;
        @(negedge clock);
        check("bypass_valid", {63'b0, inst1_opb_valid}, 64'd1);
        check("bypass_value", inst1_opb_prf_value, 64'h1234);
        tick();
        cdb2_valid = 0;
`endif

        // reset beats a concurrent CDB write
        reset = 1;
        cdb1_valid = 1; cdb1_tag = 6'd2; cdb1_out = 64'h55;
        rat1_allocate_new_prf = 1;
        tick();
        reset = 0;
        clear_inputs();
        inst1_opa_prf_idx = 6'd2;
        @(negedge clock);
        check("reset_prio_valid", {63'b0, inst1_opa_valid}, 64'd1);
        check("reset_prio_value", inst1_opa_prf_value, 64'd0);
        tick();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/physical_reg_file.md
PHYSICAL_REG_FILE -- requirements
Module: physical_reg_file

Interface
REQ-001 SHALL have parameter PRF_SIZE, default 64: number of physical registers (power of 2, >=4); IW = $clog2(PRF_SIZE).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 cdb1_valid, cdb2_valid  in  1  result broadcast valid.
REQ-006 cdb1_tag, cdb2_tag  in  IW  destination entry of broadcast.
REQ-007 cdb1_out, cdb2_out  in  64  broadcast result value.
REQ-008 inst1_opa_prf_idx, inst1_opb_prf_idx, inst2_opa_prf_idx, inst2_opb_prf_idx  in  IW  read port indices.
REQ-009 rat1_allocate_new_prf, rat2_allocate_new_prf  in  1  rename allocation request.
REQ-010 rrat1_prf_free_list, rrat2_prf_free_list  in  PRF_SIZE  bit=1: entry held by retirement table.
REQ-011 rat1_prf_free_list, rat2_prf_free_list  in  PRF_SIZE  reserved; ignored by logic.
REQ-012 rrat1_branch_mistaken_free_valid, rrat2_branch_mistaken_free_valid  in  1  mispredict recovery strobe.
REQ-013 rrat1_prf_free_valid, rrat2_prf_free_valid  in  1  retirement free strobe; rrat1_prf_free_idx, rrat2_prf_free_idx  in  IW  entry to free.
REQ-014 rat1_prf_rename_valid_out, rat2_prf_rename_valid_out  out  1  grant valid; rat1_prf_rename_idx_out, rat2_prf_rename_idx_out  out  IW  granted entry.
REQ-015 inst1_opa_valid, inst1_opb_valid, inst2_opa_valid, inst2_opb_valid  out  1  operand value ready.
REQ-016 inst1_opa_prf_value, inst1_opb_prf_value, inst2_opa_prf_value, inst2_opb_prf_value  out  64  operand value.

Function
REQ-017 Per entry state: allocated bit, ready bit, 64-bit value.
REQ-018 Grants combinational from registered state: rat1 gets lowest-index unallocated entry; rat2 gets highest-index unallocated entry distinct from rat1's grant.
REQ-019 valid_out=1 only when request asserted and a qualifying entry exists; otherwise valid_out=0, idx_out=0.
REQ-020 One free entry with both requesting: rat1 granted, rat2 invalid; zero free: both invalid.
REQ-021 Rising edge with valid grant: entry allocated=1, ready=0.
REQ-022 Rising edge with cdbN_valid: value[tag]=cdbN_out, ready[tag]=1; same tag on both CDBs: cdb1 wins.
REQ-023 Rising edge with rratN_prf_free_valid: allocated[idx]=0; both frees may occur same cycle.
REQ-024 Reads combinational: value=stored value, valid=ready bit.
REQ-025 Any mispredict strobe: at edge allocated := rrat1_prf_free_list | rrat2_prf_free_list; ready/value unchanged; grants, allocations and retirement frees that cycle suppressed; valid_out forced 0.
REQ-026 Free and allocate of same entry in one cycle: freed entry grantable next cycle only.

Reset
REQ-027 Reset: all allocated=0, ready=1, value=0; grant outputs 0; takes priority over all other inputs.

Configuration
REQ-028 Macro PRF_CDB_BYPASS_EN defined: a read whose index matches a valid CDB tag that cycle returns cdb_out (cdb1 priority) with valid=1 same cycle.
REQ-029 PRF_CDB_BYPASS_EN undefined: no bypass; CDB data readable the cycle after the edge.

Verification
REQ-030 Reset, then rat1 request alone on three alternating cycles -> idx 0, 1, 2, each valid=1; idle cycles valid=0, idx=0.
REQ-031 After reset, both request -> rat1 idx 0, rat2 idx 63, both valid.
REQ-032 Allocate entry 0; cdb1 tag 0 value 0xDEAD_BEEF; next cycle inst1_opa_prf_idx=0 -> valid=1, value 0xDEADBEEF; before write valid=0.
REQ-033 Allocate 0..63 -> next request invalid; rrat1 frees idx 5 -> following rat1 request gets idx 5.
REQ-034 Entries 0..9 allocated, mispredict with rrat1 list=0x3 -> next rat1 request gets idx 2, valid_out 0 during recovery cycle.
REQ-035 With PRF_CDB_BYPASS_EN, cdb2 tag 7 value 0x1234 while reading idx 7 -> same-cycle valid=1, value 0x1234.
